// File: rtl/apb4_master.sv
// APB4 requester: turns a valid/ready command into one APB4 transfer at a
// time and returns a registered valid/ready response. A PREADY watchdog
// aborts transfers to a stalled slave.
module apb4_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  output logic [2:0]              pprot_o,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i
);

  localparam int STRB_W = DATA_WIDTH / 8;
  // A disabled watchdog still gets a 1-bit counter so no zero-width vector appears.
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       strb_q, strb_d;
  logic [2:0]              prot_q, prot_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    accept;
  logic                    expire;

  // Next-state, request capture, watchdog and response capture.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    strb_d        = strb_q;
    prot_d        = prot_q;
    cnt_d         = cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    accept        = (state_q == S_IDLE) && req_ready_q && req_valid_i;
    // pready_i wins over expiry, so expiry is only considered with pready_i low.
    expire        = WD_EN && (cnt_q == TMO) && !pready_i;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = req_addr_i;
          write_d = req_write_i;
          wdata_d = req_wdata_i;
          // Reads must drive all-zero strobes on the bus.
          strb_d  = req_write_i ? req_strb_i : '0;
          prot_d  = req_prot_i;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready_i) begin
          rsp_rdata_d   = write_q ? '0 : prdata_i;
          rsp_err_d     = pslverr_i;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (expire) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State, captured request, watchdog and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      strb_q        <= '0;
      prot_q        <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      strb_q        <= strb_d;
      prot_q        <= prot_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Bus phase decoded from the state register, so reset drops it at once.
  assign psel_o        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable_o     = (state_q == S_ACCESS);
  assign pwrite_o      = write_q;
  assign paddr_o       = addr_q;
  assign pwdata_o      = wdata_q;
  assign pstrb_o       = strb_q;
  assign pprot_o       = prot_q;
  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_master.sv
// Bench for apb4_master with a 4-cycle watchdog: directed APB4 scenarios
// followed by randomized transfers against a rule-level response model.
module tb_apb4_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          req_write_i;
  logic [DW-1:0] req_wdata_i;
  logic [3:0]    req_strb_i;
  logic [2:0]    req_prot_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [3:0]    pstrb_o;
  logic [2:0]    pprot_o;
  logic          pready_i;
  logic          pslverr_i;
  logic [DW-1:0] prdata_i;

  int checks = 0;
  int errors = 0;

  apb4_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i), .req_prot_i(req_prot_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pprot_o(pprot_o),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic junk_req();
    req_addr_i  = $urandom;
    req_write_i = 1'($urandom);
    req_wdata_i = $urandom;
    req_strb_i  = 4'($urandom);
    req_prot_i  = 3'($urandom);
  endtask

  // One complete transfer. Slave inserts 'waits' low-pready cycles, then
  // answers with serr/rd; the response is held back for 'rdly' cycles.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input int waits,
                      input logic serr, input logic [31:0] rd, input int rdly);
    int n;
    int acc;
    int exp_acc;
    logic        ex_to;
    logic        ex_err;
    logic [31:0] ex_rd;
    logic [3:0]  ex_strb;
    ex_to   = (waits > T);
    ex_err  = ex_to ? 1'b1 : serr;
    ex_rd   = (ex_to || w) ? 32'h0 : rd;
    ex_strb = w ? st : 4'h0;
    exp_acc = ((waits > T) ? T : waits) + 1;

    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_write_i = w;
    req_wdata_i = wd;
    req_strb_i  = st;
    req_prot_i  = pr;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("accept_ready", req_ready_o, 1'b1);
    if (req_ready_o !== 1'b1) begin
      req_valid_i = 1'b0;
      return;
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    junk_req();

    chk("setup_psel", psel_o, 1'b1);
    chk("setup_penable", penable_o, 1'b0);
    chk("setup_paddr", paddr_o, a);
    chk("setup_pwrite", pwrite_o, w);
    chk("setup_pwdata", pwdata_o, wd);
    chk("setup_pstrb", pstrb_o, ex_strb);
    chk("setup_pprot", pprot_o, pr);
    chk("setup_req_ready", req_ready_o, 1'b0);
    // Must be ignored during SETUP.
    pready_i  = 1'b1;
    pslverr_i = 1'b1;
    prdata_i  = $urandom;

    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (!(psel_o === 1'b1 && penable_o === 1'b1)) break;
      acc++;
      if (acc == 2) begin
        chk("access_paddr_stable", paddr_o, a);
        chk("access_pstrb_stable", pstrb_o, ex_strb);
      end
      pready_i  = (acc > waits);
      pslverr_i = pready_i ? serr : 1'($urandom);
      prdata_i  = pready_i ? rd : $urandom;
    end
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    chk("access_len", acc, exp_acc);
    chk("resp_psel", psel_o, 1'b0);
    chk("resp_penable", penable_o, 1'b0);
    chk("rsp_valid", rsp_valid_o, 1'b1);
    chk("rsp_rdata", rsp_rdata_o, ex_rd);
    chk("rsp_err", rsp_err_o, ex_err);
    chk("rsp_timeout", rsp_timeout_o, ex_to);
    chk("resp_paddr_hold", paddr_o, a);

    for (int i = 0; i < rdly; i++) begin
      req_valid_i = 1'b1;
      junk_req();
      @(negedge clk_i);
      chk("bp_rsp_valid", rsp_valid_o, 1'b1);
      chk("bp_rsp_rdata", rsp_rdata_o, ex_rd);
      chk("bp_rsp_err", rsp_err_o, ex_err);
      chk("bp_rsp_timeout", rsp_timeout_o, ex_to);
      chk("bp_req_ready", req_ready_o, 1'b0);
      chk("bp_psel", psel_o, 1'b0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    chk("done_rsp_valid", rsp_valid_o, 1'b0);
    chk("done_req_ready", req_ready_o, 1'b1);
    chk("done_psel", psel_o, 1'b0);
    chk("done_paddr_hold", paddr_o, a);
  endtask

  // Watchdog in case the design never releases the bench.
  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  // Directed scenarios, then randomized traffic.
  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    pready_i    = 1'b0;
    pslverr_i   = 1'b0;
    prdata_i    = '0;
    junk_req();
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 1'b0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    chk("rst_rsp_err", rsp_err_o, 1'b0);
    chk("rst_rsp_timeout", rsp_timeout_o, 1'b0);
    chk("rst_psel", psel_o, 1'b0);
    chk("rst_penable", penable_o, 1'b0);
    chk("rst_pwrite", pwrite_o, 1'b0);
    chk("rst_paddr", paddr_o, 32'h0);
    chk("rst_pwdata", pwdata_o, 32'h0);
    chk("rst_pstrb", pstrb_o, 4'h0);
    chk("rst_pprot", pprot_o, 3'h0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_req_ready", req_ready_o, 1'b1);

    xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'h0, 0, 1'b0, 32'hCAFEF00D, 0);
    xfer(32'h08, 1'b0, 32'h0, 4'hF, 3'h2, 3, 1'b0, 32'h12345678, 0);
    xfer(32'h20, 1'b1, 32'hA5A5A5A5, 4'h3, 3'h1, 1, 1'b1, 32'h0, 0);
    xfer(32'h24, 1'b0, 32'h0, 4'hF, 3'h0, 0, 1'b1, 32'h55AA55AA, 0);
    xfer(32'h30, 1'b0, 32'h0, 4'hF, 3'h5, 50, 1'b0, 32'hFFFFFFFF, 0);
    xfer(32'h34, 1'b0, 32'h0, 4'hF, 3'h5, T, 1'b0, 32'h13579BDF, 0);
    xfer(32'h38, 1'b1, 32'h01020304, 4'hC, 3'h7, 2, 1'b0, 32'h0, 6);
    xfer(32'h3C, 1'b0, 32'h0, 4'h1, 3'h3, 0, 1'b0, 32'h89ABCDEF, 0);

    // Reset while the transfer sits in ACCESS.
    req_valid_i = 1'b1;
    req_addr_i  = 32'h40;
    req_write_i = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("rstmid_setup_psel", psel_o, 1'b1);
    @(negedge clk_i);
    chk("rstmid_access_penable", penable_o, 1'b1);
    #1 rst_i = 1'b1;
    #1;
    chk("rstmid_psel", psel_o, 1'b0);
    chk("rstmid_penable", penable_o, 1'b0);
    chk("rstmid_rsp_valid", rsp_valid_o, 1'b0);
    pready_i = 1'b1;
    prdata_i = 32'h0BAD0BAD;
    @(negedge clk_i);
    rst_i    = 1'b0;
    pready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("rstmid_after_req_ready", req_ready_o, 1'b1);
      chk("rstmid_after_rsp_valid", rsp_valid_o, 1'b0);
      chk("rstmid_after_psel", psel_o, 1'b0);
    end

    for (int k = 0; k < 40; k++) begin
      xfer($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
           int'($urandom_range(0, 7)), 1'($urandom), $urandom,
           int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb4_master.md
# apb4_master

APB4 requester that converts a simple valid/ready command/response pair into APB4 bus transfers. It is the initiator counterpart of the codebase's APB4 slave peripherals such as the RTC. It sits between a CPU-side or DMA-side command source and an APB4 segment. It issues one transfer at a time and has a programmable PREADY watchdog, so a stalled slave cannot hang the requester.

## Interface
- ADDR_WIDTH, 32: paddr/req_addr width
- DATA_WIDTH, 32: data width; must be 8, 16 or 32
- TIMEOUT, 255: max wait cycles in ACCESS with pready_i low; 0 disables the watchdog
- clk_i  in  1  single clock (APB PCLK domain)
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  command valid
- req_ready_o  out  1  command ready
- req_addr_i  in  ADDR_WIDTH  target address
- req_write_i  in  1  1 = write, 0 = read
- req_wdata_i  in  DATA_WIDTH  write data
- req_strb_i  in  DATA_WIDTH/8  write byte strobes
- req_prot_i  in  3  protection attribute
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes)
- rsp_err_o  out  1  pslverr_i or timeout
- rsp_timeout_o  out  1  transfer aborted by watchdog
- psel_o, penable_o, pwrite_o  out  1  APB4 control
- paddr_o  out  ADDR_WIDTH; pwdata_o  out  DATA_WIDTH; pstrb_o  out  DATA_WIDTH/8; pprot_o  out  3
- pready_i, pslverr_i  in  1; prdata_i  in  DATA_WIDTH

## Operation
- FSM states and transitions:
  - IDLE: a handshake (req_valid_i & req_ready_o) latches addr, write, wdata, prot and the strobes, then goes to SETUP.
  - SETUP: lasts one cycle, then goes to ACCESS.
  - ACCESS: waits for pready_i or timeout, then goes to RESP.
  - RESP: on rsp_ready_i, goes to IDLE.
- Bus drive:
  - SETUP: psel_o=1, penable_o=0.
  - ACCESS: psel_o=1, penable_o=1.
  - IDLE and RESP: psel_o=0, penable_o=0.
- Address/control/data stability: paddr_o, pwrite_o, pwdata_o, pstrb_o and pprot_o are registered at accept. They stay stable through SETUP and ACCESS and hold their last value in IDLE and RESP, with no toggling.
- Strobes: pstrb_o = req_strb_i if write, else all zeros (APB4 read rule).
- pready_i and pslverr_i are sampled only in ACCESS; values in SETUP are ignored.
- Completion on pready_i=1 in ACCESS:
  - rsp_rdata_o = prdata_i for reads, 0 for writes.
  - rsp_err_o = pslverr_i.
  - rsp_timeout_o = 0.
- Watchdog: a counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0.
  - If the counter equals TIMEOUT while pready_i=0, the transfer aborts: go to RESP with rsp_err_o=1, rsp_timeout_o=1 and rsp_rdata_o=0.
  - pready_i=1 in the same cycle as expiry takes precedence, giving a normal completion.
  - Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
- req_ready_o is registered and equals (next_state==IDLE). It is 1 in IDLE only, and req_* are ignored outside IDLE.
- rsp_* are registered and held constant while rsp_valid_o=1 && rsp_ready_i=0.

## Timing
- Reset values: every output is 0 (req_ready_o, rsp_*, psel_o, penable_o, paddr_o, pwdata_o, pstrb_o, pprot_o, pwrite_o). The state resets to IDLE.
- req_ready_o rises on the first clk_i edge after rst_i falls.
- Accept at edge N gives:
  - SETUP during cycle N+1.
  - ACCESS from cycle N+2.
  - Zero-wait slave (pready_i=1 in first ACCESS cycle): rsp_valid_o=1 in cycle N+3.
  - Each wait state adds one cycle.
- With rsp_ready_i held at 1, RESP lasts one cycle and the next accept can occur in cycle N+4, so minimum throughput is one transfer per 4 cycles.
- Timeout with TIMEOUT=T and pready_i stuck at 0:
  - ACCESS lasts T+1 cycles.
  - psel_o/penable_o drop after the (T+1)th ACCESS cycle.
  - rsp_valid_o=1 in the next cycle.
- rst_i asserted mid-transfer: psel_o/penable_o clear immediately (asynchronously). Any pending response is discarded with no rsp_valid_o, and the FSM restarts in IDLE.

## Test plan
- Reset release, then a write to 0x10 with data 0xDEADBEEF, strb 0xF and zero-wait slave: psel_o=1 for 2 cycles, penable_o=1 for 1 cycle, pstrb_o=0xF. rsp_valid_o appears 3 cycles after accept with rsp_err_o=0 and rsp_rdata_o=0.
- Read of 0x08 with req_strb_i=0xF and a slave that waits 3 cycles then returns 0x12345678: pstrb_o=0, ACCESS lasts 4 cycles, rsp_rdata_o=0x12345678.
- Slave returns pslverr_i=1 with pready_i=1: rsp_err_o=1, rsp_timeout_o=0.
- TIMEOUT=4 with pready_i stuck at 0: ACCESS lasts 5 cycles, then rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0. Repeat with pready_i=1 on the 5th ACCESS cycle: normal completion, rsp_timeout_o=0.
- Back-pressure: rsp_ready_i=0 for 6 cycles while req_valid_i stays 1. rsp_* stay stable, req_ready_o stays 0 and psel_o stays 0. After rsp_ready_i=1, the next request is accepted one cycle later.
- Assert rst_i during ACCESS: psel_o and penable_o fall in the same cycle, no response is produced, and req_ready_o=1 after release.
